// File: rtl/ram_bank_be.sv
// Byte-strobed synchronous word memory with a pipelined, valid-tagged read port.
// Out-of-range accesses are flagged and never alias onto real words.
module ram_bank_be #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int MEM_NUM = 4096,
  parameter int RD_LAT  = 1,
  parameter int BYPASS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic [AW-1:0]   w_addr,
  input  logic [DW-1:0]   w_data,
  input  logic [DW/8-1:0] w_strb,
  output logic            w_err,
  input  logic            ren,
  input  logic [AW-1:0]   r_addr,
  output logic [DW-1:0]   r_data,
  output logic            r_valid,
  output logic            r_err
);

  localparam int BW  = DW / 8;
  localparam int OFS = (BW > 1) ? $clog2(BW) : 0;
  localparam int IW  = AW - OFS;
  localparam int MAW = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;

  if ((DW % 8) != 0 || DW < 8) begin : g_chk_dw
    $error("ram_bank_be: DW must be a non-zero multiple of 8");
  end
  if (MEM_NUM < 1) begin : g_chk_num
    $error("ram_bank_be: MEM_NUM must be at least 1");
  end
  if (RD_LAT < 1 || RD_LAT > 2) begin : g_chk_lat
    $error("ram_bank_be: RD_LAT must be 1 or 2");
  end

  if (OFS > 0) begin : g_ofs
    logic unused_ofs;
    assign unused_ofs = ^{w_addr[OFS-1:0], r_addr[OFS-1:0]};
  end

  logic [DW-1:0] mem_q [MEM_NUM];

  logic [IW-1:0]  w_idx;
  logic [IW-1:0]  r_idx;
  logic [MAW-1:0] w_word;
  logic [MAW-1:0] r_word;
  logic           w_in;
  logic           r_in;
  logic           w_hit;
  logic [DW-1:0]  rd_word;
  logic [DW-1:0]  d1_d;

  // Full index is compared so high address bits can never wrap into the array.
  assign w_idx  = w_addr[AW-1:OFS];
  assign r_idx  = r_addr[AW-1:OFS];
  assign w_in   = 64'(w_idx) < 64'(MEM_NUM);
  assign r_in   = 64'(r_idx) < 64'(MEM_NUM);
  assign w_word = MAW'(w_idx);
  assign r_word = MAW'(r_idx);
  assign w_hit  = wen && w_in && (w_idx == r_idx);

  always_comb begin
    rd_word = mem_q[r_word];
    if (BYPASS != 0 && w_hit) begin
      for (int i = 0; i < BW; i++) begin
        if (w_strb[i]) rd_word[8*i +: 8] = w_data[8*i +: 8];
      end
    end
    d1_d = r_in ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst && wen && w_in) begin
      for (int i = 0; i < BW; i++) begin
        if (w_strb[i]) mem_q[w_word][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end

  logic          w_err_q;
  logic          v1_q;
  logic          e1_q;
  logic [DW-1:0] d1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_err_q <= 1'b0;
      v1_q    <= 1'b0;
      e1_q    <= 1'b0;
      d1_q    <= '0;
    end else begin
      w_err_q <= wen && !w_in;
      v1_q    <= ren;
      e1_q    <= ren && !r_in;
      if (ren) d1_q <= d1_d;
    end
  end

  assign w_err = w_err_q;

  if (RD_LAT == 2) begin : g_lat2
    logic          v2_q;
    logic          e2_q;
    logic [DW-1:0] d2_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q <= 1'b0;
        e2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        e2_q <= e1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end

    assign r_valid = v2_q;
    assign r_err   = e2_q;
    assign r_data  = d2_q;
  end else begin : g_lat1
    assign r_valid = v1_q;
    assign r_err   = e1_q;
    assign r_data  = d1_q;
  end

endmodule

// File: tb/tb_ram_bank_be.sv
// Bench for ram_bank_be: two instances (lat1/bypass, lat2/no-bypass) on shared
// inputs, checked by a word-map reference model plus a hand-derived vector table.
module tb_ram_bank_be;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wen, ren;
  logic [31:0] w_addr, w_data, r_addr;
  logic [3:0]  w_strb;
  logic [31:0] rd_a, rd_b;
  logic        rv_a, re_a, we_a, rv_b, re_b, we_b;

  ram_bank_be #(.DW(32), .AW(32), .MEM_NUM(4096), .RD_LAT(1), .BYPASS(1)) dut_a (
    .clk(clk), .rst(rst), .wen(wen), .w_addr(w_addr), .w_data(w_data),
    .w_strb(w_strb), .w_err(we_a), .ren(ren), .r_addr(r_addr),
    .r_data(rd_a), .r_valid(rv_a), .r_err(re_a));

  ram_bank_be #(.DW(32), .AW(32), .MEM_NUM(4096), .RD_LAT(2), .BYPASS(0)) dut_b (
    .clk(clk), .rst(rst), .wen(wen), .w_addr(w_addr), .w_data(w_data),
    .w_strb(w_strb), .w_err(we_b), .ren(ren), .r_addr(r_addr),
    .r_data(rd_b), .r_valid(rv_b), .r_err(re_b));

  int total = 0;
  int bad   = 0;
  int edge_n = 0;

  // Reference model: word map plus per-instance response schedule by edge number.
  logic [31:0] mdl [int unsigned];
  int          lat [2] = '{1, 2};
  bit          byp [2] = '{1'b1, 1'b0};
  bit          sv  [2][8];
  bit          se  [2][8];
  logic [31:0] sd  [2][8];
  logic [31:0] hold[2];
  bit          xv  [2];
  bit          xe  [2];
  logic [31:0] xd  [2];
  bit          xw;

  function automatic bit oor(logic [31:0] a);
    return (a >> 2) >= 32'd4096;
  endfunction

  function automatic logic [31:0] peek(logic [31:0] a);
    if (mdl.exists(a >> 2)) return mdl[a >> 2];
    return 'x;
  endfunction

  task automatic model_step();
    int          s;
    logic [31:0] w;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 8; j++) sv[k][j] = 1'b0;
        hold[k] = '0; xv[k] = 1'b0; xe[k] = 1'b0; xd[k] = '0;
      end
      xw = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (ren) begin
          s = (edge_n + lat[k] - 1) % 8;
          sv[k][s] = 1'b1;
          se[k][s] = oor(r_addr);
          w = '0;
          if (!oor(r_addr)) begin
            w = peek(r_addr);
            if (byp[k] && wen && !oor(w_addr) && (w_addr >> 2) == (r_addr >> 2))
              for (int b = 0; b < 4; b++)
                if (w_strb[b]) w[8*b +: 8] = w_data[8*b +: 8];
          end
          sd[k][s] = w;
        end
      end
      if (wen && !oor(w_addr)) begin
        w = peek(w_addr);
        for (int b = 0; b < 4; b++)
          if (w_strb[b]) w[8*b +: 8] = w_data[8*b +: 8];
        mdl[w_addr >> 2] = w;
      end
      xw = wen && oor(w_addr);
      for (int k = 0; k < 2; k++) begin
        s = edge_n % 8;
        if (sv[k][s]) begin
          xv[k] = 1'b1; xe[k] = se[k][s]; xd[k] = sd[k][s];
          hold[k] = sd[k][s]; sv[k][s] = 1'b0;
        end else begin
          xv[k] = 1'b0; xe[k] = 1'b0; xd[k] = hold[k];
        end
      end
    end
    edge_n++;
  endtask

  task automatic chk(string nm, bit v, bit e, logic [31:0] d, bit we,
                     bit ev, bit ee, logic [31:0] ed, bit ew);
    total++;
    if ({v, e, d, we} !== {ev, ee, ed, ew}) begin
      bad++;
      $display("FAIL %s edge=%0d got v=%b e=%b d=%h werr=%b want v=%b e=%b d=%h werr=%b",
               nm, edge_n, v, e, d, we, ev, ee, ed, ew);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_a", rv_a, re_a, rd_a, we_a, xv[0], xe[0], xd[0], xw);
    chk("model_b", rv_b, re_b, rd_b, we_b, xv[1], xe[1], xd[1], xw);
  endtask

  task automatic drive(bit r, bit we_, logic [31:0] wa, logic [31:0] wd,
                       logic [3:0] ws, bit re_, logic [31:0] ra);
    rst = r; wen = we_; w_addr = wa; w_data = wd; w_strb = ws;
    ren = re_; r_addr = ra;
  endtask

  typedef struct {
    bit          rst, wen;
    logic [31:0] wa, wd;
    logic [3:0]  ws;
    bit          ren;
    logic [31:0] ra;
    bit          xv, xe;
    logic [31:0] xd;
    bit          xw;
  } vec_t;

  function automatic vec_t mk(bit r, bit we_, logic [31:0] wa, logic [31:0] wd,
                              logic [3:0] ws, bit re_, logic [31:0] ra,
                              bit ev, bit ee, logic [31:0] ed, bit ew);
    vec_t t;
    t.rst = r; t.wen = we_; t.wa = wa; t.wd = wd; t.ws = ws;
    t.ren = re_; t.ra = ra; t.xv = ev; t.xe = ee; t.xd = ed; t.xw = ew;
    return t;
  endfunction

  vec_t tbl [25];

  initial begin
    // Expectations below are for the RD_LAT=1, BYPASS=1 instance.
    tbl[0]  = mk(1, 1, 32'h100, 32'hFFFFFFFF, 4'hF, 1, 32'h100, 0, 0, 32'h0, 0);
    tbl[1]  = mk(0, 1, 32'h100, 32'hDEADBEEF, 4'hF, 1, 32'h100, 1, 0, 32'hDEADBEEF, 0);
    tbl[2]  = mk(0, 1, 32'h100, 32'h0000AA00, 4'h2, 1, 32'h100, 1, 0, 32'hDEADAAEF, 0);
    tbl[3]  = mk(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h103, 1, 0, 32'hDEADAAEF, 0);
    tbl[4]  = mk(1, 1, 32'h100, 32'h12345678, 4'hF, 1, 32'h100, 0, 0, 32'h0, 0);
    tbl[5]  = mk(1, 1, 32'h100, 32'h12345678, 4'hF, 1, 32'h100, 0, 0, 32'h0, 0);
    tbl[6]  = mk(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h100, 1, 0, 32'hDEADAAEF, 0);
    tbl[7]  = mk(0, 1, 32'h0, 32'h1, 4'hF, 0, 32'h0, 0, 0, 32'hDEADAAEF, 0);
    tbl[8]  = mk(0, 1, 32'h4, 32'h2, 4'hF, 0, 32'h0, 0, 0, 32'hDEADAAEF, 0);
    tbl[9]  = mk(0, 1, 32'h8, 32'h3, 4'hF, 0, 32'h0, 0, 0, 32'hDEADAAEF, 0);
    tbl[10] = mk(0, 1, 32'hC, 32'h4, 4'hF, 0, 32'h0, 0, 0, 32'hDEADAAEF, 0);
    tbl[11] = mk(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 1, 0, 32'h1, 0);
    tbl[12] = mk(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h4, 1, 0, 32'h2, 0);
    tbl[13] = mk(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h8, 1, 0, 32'h3, 0);
    tbl[14] = mk(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'hC, 1, 0, 32'h4, 0);
    tbl[15] = mk(0, 1, 32'h20, 32'h55, 4'hF, 0, 32'h0, 0, 0, 32'h4, 0);
    tbl[16] = mk(0, 1, 32'h20, 32'h11223344, 4'hF, 1, 32'h20, 1, 0, 32'h11223344, 0);
    tbl[17] = mk(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h20, 1, 0, 32'h11223344, 0);
    tbl[18] = mk(0, 1, 32'h4000, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 0, 0, 32'h11223344, 1);
    tbl[19] = mk(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 32'h11223344, 0);
    tbl[20] = mk(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h4000, 1, 1, 32'h0, 0);
    tbl[21] = mk(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h0, 1, 0, 32'h1, 0);
    tbl[22] = mk(0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h80000000, 1, 1, 32'h0, 0);
    tbl[23] = mk(0, 1, 32'h4000, 32'hFFFFFFFF, 4'hF, 1, 32'h0, 1, 0, 32'h1, 1);
    tbl[24] = mk(0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, 0, 0, 32'h1, 0);

    for (int k = 0; k < 2; k++) hold[k] = '0;
    drive(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].wen, tbl[i].wa, tbl[i].wd, tbl[i].ws,
            tbl[i].ren, tbl[i].ra);
      cycle();
      chk($sformatf("vec%0d", i), rv_a, re_a, rd_a, we_a,
          tbl[i].xv, tbl[i].xe, tbl[i].xd, tbl[i].xw);
    end

    // Reset must discard a read in flight in the two-stage pipe.
    drive(0, 1, 32'h40, 32'hCAFEF00D, 4'hF, 0, 0);
    cycle();
    drive(0, 0, 0, 0, 0, 1, 32'h40);
    cycle();
    chk("lat1_40", rv_a, re_a, rd_a, we_a, 1, 0, 32'hCAFEF00D, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("rst_b", rv_b, re_b, rd_b, we_b, 0, 0, 32'h0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("flush_b", rv_b, re_b, rd_b, we_b, 0, 0, 32'h0, 0);

    // Preload the random window so every in-range read hits a known word.
    for (int i = 0; i < 32; i++) begin
      drive(0, 1, 32'(i * 4), $urandom, 4'hF, 0, 0);
      cycle();
    end

    for (int n = 0; n < 1500; n++) begin
      logic [31:0] a [2];
      for (int j = 0; j < 2; j++) begin
        case ($urandom_range(0, 19))
          0:       a[j] = 32'h4000 + $urandom_range(0, 255);
          1:       a[j] = 32'hFFFFFFFC;
          2:       a[j] = 32'h80000000 | $urandom_range(0, 127);
          default: a[j] = $urandom_range(0, 127);
        endcase
      end
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 1) == 1, a[0],
            $urandom, 4'($urandom), $urandom_range(0, 9) < 6, a[1]);
      cycle();
    end

    drive(0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
